div_unit32: RTL and testbench

- Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions in the execute stage.
- Restoring radix-2 algorithm: one trial subtraction per cycle on a 33-bit partial remainder, using the same add/subtract datapath style as the ALU.
- Fixed latency with a start/busy/done handshake, so the pipeline can stall the execute stage deterministically.

---
 rtl/div_unit32.sv | 148 ++++++++++++++
 tb/tb_div_unit32.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit32.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Fixed 32-cycle RUN phase followed by a one-cycle DONE pulse.
module div_unit32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [1:0]      op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] dvd_reg;
    logic [XLEN-1:0] dvs_reg;
    logic [XLEN-1:0] quo_reg;
    logic [XLEN:0]   rem_reg;
    logic [4:0]      cnt_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [XLEN-1:0] result_reg;

    logic            start_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial;
    logic            qbit;
    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] q_signed;
    logic [XLEN-1:0] r_signed;
    logic            is_rem;
    logic            is_signed;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] final_next;

    // Operand magnitudes captured at acceptance; 0x80000000 maps to itself.
    always_comb begin
        start_signed = ~op[0];
        abs_a = (start_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
        abs_b = (start_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
    end

    always_comb begin
        rem_shift = {rem_reg[XLEN-1:0], dvd_reg[XLEN-1]};
        trial     = rem_shift - {1'b0, dvs_reg};
        qbit      = ~trial[XLEN];
        rem_next  = qbit ? trial : rem_shift;
        quo_next  = {quo_reg[XLEN-2:0], qbit};
        q_signed  = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
        r_signed  = neg_r_reg ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];
        is_rem    = op_reg[1];
        is_signed = ~op_reg[0];
        div_zero  = (b_reg == '0);
        ovf       = is_signed && (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
        // Architecturally defined results take priority over the iterative one.
        if (div_zero) begin
            final_next = is_rem ? a_reg : '1;
        end else if (ovf) begin
            final_next = is_rem ? '0 : 32'h8000_0000;
        end else begin
            final_next = is_rem ? r_signed : q_signed;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            cnt_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        op_reg    <= op;
                        a_reg     <= a;
                        b_reg     <= b;
                        dvd_reg   <= abs_a;
                        dvs_reg   <= abs_b;
                        quo_reg   <= '0;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        neg_q_reg <= start_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        neg_r_reg <= start_signed && a[XLEN-1];
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    dvd_reg <= {dvd_reg[XLEN-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        result_reg <= final_next;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_div_unit32.sv
// Scoreboard bench for div_unit32: directed vectors push expectations, a
// negedge monitor pops and checks them on every done pulse.
module tb_div_unit32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    localparam logic [1:0] OP_DIV  = 2'd0;
    localparam logic [1:0] OP_DIVU = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] OP_REMU = 2'd3;

    typedef struct {
        logic [31:0] res;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    div_unit32 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_latency"}, cyc - e.acc, 32'd32);
                chk({e.name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
                $display("txn %s: result=0x%08h expected=0x%08h cycles=%0d",
                         e.name, result, e.res, cyc - e.acc);
            end
        end
    end

    // Issue one operation, scramble the inputs after acceptance, wait for idle.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] exp);
        exp_t e;
        int   n;
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        e.res = exp; e.acc = cyc; e.name = name;
        sb.push_back(e);
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("div_by0",    OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("divu_by0",   OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0",    OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("remu_by0",   OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("divu_ovf",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("remu_ovf",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

        // Starts at +5 and +33 are ignored; a start at +34 is accepted.
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        e.res = 32'd14; e.acc = cyc; e.name = "busy_ignore";
        sb.push_back(e);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op = OP_DIVU; a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (27) @(posedge clk);
        #1;
        chk("plus33_done", {31'd0, done}, 32'd1);
        op = OP_REMU; a = 32'd77; b = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        chk("plus34_busy", {31'd0, busy}, 32'd0);
        chk("plus34_done", {31'd0, done}, 32'd0);
        chk("plus34_result_held", result, 32'd14);
        op = OP_DIVU; a = 32'd1000; b = 32'd10;
        @(posedge clk); #1;
        e.res = 32'd100; e.acc = cyc; e.name = "plus34_start";
        sb.push_back(e);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("plus34_idle", {31'd0, busy}, 32'd0);

        // Reset mid-run: no done pulse may follow (monitor flags a spurious one).
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        run_op("after_rst", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
